dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far side of the MEM stage's load/store request path.
- Accepts one load or store request at a time over a valid/ready handshake.
- Models a configurable access latency, performs the access on an internal byte-addressed array, and returns read data, an error flag and a write-success flag over a valid/ready response channel.
- Replaces the single-cycle memory model when the pipeline runs with stall-capable memory timing.

Parameters:
- DEPTH_BYTES, 512, array size in bytes; power of two, minimum 4.
- LATENCY, 2, cycles spent in BUSY before the response is presented; 0 is legal and skips BUSY.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset; rst=0 resets the block
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  16  byte address
- req_wdata  in  16  store data
- req_wr  in  2  access type: 00 word load, 01 byte store (req_wdata[7:0]), 11 word store, 10 reserved
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  16  load data; 0 for stores and errors
- rsp_err  out  1  request faulted
- rsp_wr_success  out  1  store committed to the array

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; the latency counter clears.
  - req_ready=0 while in reset, then 1 in IDLE.
  - rsp_valid, rsp_rdata, rsp_err and rsp_wr_success all reset to 0.
  - Array contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, capture addr, wdata and req_wr. Go to BUSY with counter=LATENCY-1, or straight to RESP if LATENCY=0.
  - BUSY: req_ready=0. Decrement the counter each cycle; on counter==0 perform the access and go to RESP.
  - RESP: rsp_valid=1; all rsp_* outputs held stable. On rsp_ready, go to IDLE.
- Request-to-response latency: rsp_valid rises LATENCY+1 cycles after the accepting edge. No back-to-back acceptance; throughput is at most one request per LATENCY+2 cycles.
- Error conditions (rsp_err=1, array unchanged, rsp_rdata=0, rsp_wr_success=0):
  - req_wr=10.
  - Word access (00 or 11) with addr[0]=1.
  - addr >= DEPTH_BYTES.
- Byte order is little-endian:
  - Word at even address A = {mem[A+1], mem[A]}.
  - Byte store writes mem[addr] only; addr[0] may be 1.
- Word load: rsp_rdata = word at addr; rsp_wr_success=0.
- Any successful store: rsp_wr_success=1; rsp_rdata=0.
- The array is written exactly once per store, on the BUSY-to-RESP (or IDLE-to-RESP) transition. It is never rewritten while the block waits in RESP.
- Read of a location stored by the immediately preceding request returns the new data.
- Reset asserted mid-BUSY or mid-RESP:
  - The request is dropped and no response is produced.
  - A store not yet committed must not modify the array.
- req_valid while req_ready=0 is ignored. The requester must hold req_* stable until accepted.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_rd_cnt, perf_wr_cnt and perf_err_cnt, each 16 bits.
  - Each counter counts completed responses (RESP exit with rsp_ready) of its kind: successful loads, successful stores, errors.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- LATENCY=2: word store 16'hBEEF at 0x0010, then load 0x0010.
  -> Store response: wr_success=1, err=0, arriving 3 cycles after acceptance.
  -> Load response: rdata=16'hBEEF.
- Byte store 16'h00AA at 0x0011 after a word store of 16'h1234 at 0x0010, then load 0x0010.
  -> rdata=16'hAA34.
- Load at 0x0003; word store at 0x0005; req_wr=10; load at DEPTH_BYTES.
  -> Each gives rsp_err=1, rdata=0, wr_success=0.
  -> A load at 0x0004 afterwards returns its prior value.
- Hold rsp_ready=0 for 5 cycles in RESP.
  -> rsp_valid and data stay stable; req_ready=0 throughout.
  -> Exactly one response is consumed when rsp_ready=1.
- Assert rst=0 during BUSY of a word store 16'h5555 to 0x0020 (location previously 16'h0001), then release.
  -> No rsp_valid; IDLE with req_ready=1.
  -> Load 0x0020 returns 16'h0001.
- LATENCY=0 with DMEM_PERF_CNT_EN: 3 loads, 2 stores, 1 error.
  -> Each response arrives 1 cycle after acceptance.
  -> perf_rd_cnt=3, perf_wr_cnt=2, perf_err_cnt=1.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed access latency, valid/ready response.
// Optional saturating response counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_responder #(
  parameter int DEPTH_BYTES = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_wr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_wr_success
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0] perf_rd_cnt,
  output logic [15:0] perf_wr_cnt,
  output logic [15:0] perf_err_cnt
`endif
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
  // the source holds its payload stable from raising valid until that edge.

  localparam int AW     = $clog2(DEPTH_BYTES);
  localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [1:0]      wr_q, wr_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_wr_success_q, rsp_wr_success_d;

  logic [7:0]      mem [DEPTH_BYTES];

  logic [15:0]     acc_addr;
  logic [15:0]     acc_wdata;
  logic [1:0]      acc_wr;
  logic            acc_bad;
  logic [15:0]     acc_word;
  logic            commit;
  logic            wr_en;

  // With LATENCY=0 the access happens on the accepting edge, so it must see the live request.
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_wr    = (state_q == IDLE) ? req_wr    : wr_q;
  assign acc_bad   = (acc_wr == 2'b10) ||
                     ((acc_wr != 2'b01) && acc_addr[0]) ||
                     ({1'b0, acc_addr} >= DEPTH_L);
  assign acc_word  = {mem[{acc_addr[AW-1:1], 1'b1}], mem[{acc_addr[AW-1:1], 1'b0}]};
  assign wr_en     = commit && !acc_bad && acc_wr[0];

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wr_d             = wr_q;
    req_ready_d      = req_ready_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_rdata_d      = rsp_rdata_q;
    rsp_err_d        = rsp_err_q;
    rsp_wr_success_d = rsp_wr_success_q;
    commit           = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          wr_d        = req_wr;
          req_ready_d = 1'b0;
          if (LATENCY == 0) begin
            commit = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(LAT_M1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) commit = 1'b1;
        else             cnt_d  = cnt_q - CW'(1);
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      state_d          = RESP;
      rsp_valid_d      = 1'b1;
      rsp_err_d        = acc_bad;
      rsp_wr_success_d = !acc_bad && acc_wr[0];
      rsp_rdata_d      = (!acc_bad && !acc_wr[0]) ? acc_word : 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wr_q             <= '0;
      req_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_err_q        <= 1'b0;
      rsp_wr_success_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      wr_q             <= wr_d;
      req_ready_q      <= req_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_err_q        <= rsp_err_d;
      rsp_wr_success_q <= rsp_wr_success_d;
    end
  end

  // Array has no reset; a store is committed exactly once, on entry to RESP.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (acc_wr == 2'b11) begin
        mem[{acc_addr[AW-1:1], 1'b0}] <= acc_wdata[7:0];
        mem[{acc_addr[AW-1:1], 1'b1}] <= acc_wdata[15:8];
      end else begin
        mem[acc_addr[AW-1:0]] <= acc_wdata[7:0];
      end
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_wr_success = rsp_wr_success_q;

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
  logic        done;

  assign done = (state_q == RESP) && rsp_ready;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (done) begin
      if (rsp_err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end else if (rsp_wr_success_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign perf_rd_cnt  = rd_cnt_q;
  assign perf_wr_cnt  = wr_cnt_q;
  assign perf_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance share clock, reset and request bus.
// Directed vector table, reset/hold corner sequences, and randomized ops against a byte-array model.
module tb_dmem_responder;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rv = 1'b0, rrdy = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_wr = '0;
  int          sel = 0;

  logic        rv2, rv0, rrdy2, rrdy0;
  logic        rr2, rr0, vl2, vl0, er2, er0, ws2, ws0;
  logic [15:0] rd2, rd0;
  logic        s_req_ready, s_rsp_valid, s_err, s_ws;
  logic [15:0] s_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [DEPTH];

  typedef struct {
    int          dut;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wr;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic        exp_ws;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign rv2   = rv   && (sel == 0);
  assign rv0   = rv   && (sel == 1);
  assign rrdy2 = rrdy && (sel == 0);
  assign rrdy0 = rrdy && (sel == 1);
  assign s_req_ready = (sel == 0) ? rr2 : rr0;
  assign s_rsp_valid = (sel == 0) ? vl2 : vl0;
  assign s_rdata     = (sel == 0) ? rd2 : rd0;
  assign s_err       = (sel == 0) ? er2 : er0;
  assign s_ws        = (sel == 0) ? ws2 : ws0;

`ifdef DMEM_PERF_CNT_EN
  logic [15:0] prd2, pwr2, per2, prd0, pwr0, per0;
`endif

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rr2), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wr(req_wr), .rsp_valid(vl2), .rsp_ready(rrdy2),
    .rsp_rdata(rd2), .rsp_err(er2), .rsp_wr_success(ws2)
`ifdef DMEM_PERF_CNT_EN
    , .perf_rd_cnt(prd2), .perf_wr_cnt(pwr2), .perf_err_cnt(per2)
`endif
  );

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wr(req_wr), .rsp_valid(vl0), .rsp_ready(rrdy0),
    .rsp_rdata(rd0), .rsp_err(er0), .rsp_wr_success(ws0)
`ifdef DMEM_PERF_CNT_EN
    , .perf_rd_cnt(prd0), .perf_wr_cnt(pwr0), .perf_err_cnt(per0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] wr,
                           output bit ok);
    int n;
    @(negedge clk);
    req_addr = a; req_wdata = wd; req_wr = wr; rv = 1'b1;
    n = 0;
    while (!s_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_req_ready) begin
      chk("accept_timeout", 0, 1);
      rv = 1'b0;
      ok = 0;
      return;
    end
    @(posedge clk);
    #1 rv = 1'b0;
    ok = 1;
  endtask

  task automatic finish_rsp(input int hold, output logic [15:0] rd, output logic e,
                            output logic w, output int lat, output bit ok);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_rsp_valid && k < 40);
    lat = k;
    if (!s_rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      ok = 0;
      return;
    end
    rd = s_rdata; e = s_err; w = s_ws;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", s_rsp_valid, 1);
      chk("hold_rdata", s_rdata, rd);
      chk("hold_flags", {s_err, s_ws}, {e, w});
      chk("hold_req_ready", s_req_ready, 0);
    end
    rrdy = 1'b1;
    @(posedge clk);
    #1 rrdy = 1'b0;
    @(negedge clk);
    chk("single_consume", s_rsp_valid, 0);
    ok = 1;
  endtask

  task automatic do_req(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] wr,
                        input int hold, output logic [15:0] rd, output logic e,
                        output logic w, output int lat, output bit ok);
    start_req(a, wd, wr, ok);
    rd = '0; e = 1'b0; w = 1'b0; lat = 0;
    if (ok) finish_rsp(hold, rd, e, w, lat, ok);
  endtask

  // Reference: little-endian byte array with the error rules applied first.
  task automatic model_op(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] wr,
                          output logic [15:0] er, output logic ee, output logic ew);
    int  ai;
    bit  is_word;
    ai = int'(a);
    is_word = (wr == 2'b00) || (wr == 2'b11);
    er = 16'h0; ee = 1'b0; ew = 1'b0;
    if (wr == 2'b10 || (is_word && a[0]) || ai >= DEPTH) begin
      ee = 1'b1;
    end else if (wr == 2'b00) begin
      er = {model_mem[ai + 1], model_mem[ai]};
    end else if (wr == 2'b01) begin
      model_mem[ai] = wd[7:0];
      ew = 1'b1;
    end else begin
      model_mem[ai]     = wd[7:0];
      model_mem[ai + 1] = wd[15:8];
      ew = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] rd, er, a, wd;
    logic        e, w, ee, ew;
    logic [1:0]  wr;
    int          lat;
    bit          ok;

    vecs.push_back('{0, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b0});
    vecs.push_back('{0, 16'h0010, 16'h1234, 2'b11, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{0, 16'h0011, 16'h00AA, 2'b01, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{0, 16'h0010, 16'h0000, 2'b00, 16'hAA34, 1'b0, 1'b0});
    vecs.push_back('{0, 16'h0004, 16'hCAFE, 2'b11, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{0, 16'h0003, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{0, 16'h0005, 16'hFFFF, 2'b11, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{0, 16'h0004, 16'h7777, 2'b10, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{0, 16'h0200, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{0, 16'h0004, 16'h0000, 2'b00, 16'hCAFE, 1'b0, 1'b0});
    vecs.push_back('{0, 16'h0020, 16'h0001, 2'b11, 16'h0000, 1'b0, 1'b1});

    // Reset state
    #2;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", rr2, 0);
    chk("rst_rsp_valid", vl2, 0);
    chk("rst_outputs", {rd2, er2, ws2}, 0);
    chk("rst_req_ready_l0", rr0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_req_ready", rr2, 1);
    chk("idle_req_ready_l0", rr0, 1);

    foreach (vecs[i]) begin
      if (vecs[i].dut != 0) continue;
      sel = 0;
      do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wr, 0, rd, e, w, lat, ok);
      if (!ok) continue;
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      chk($sformatf("vec%0d_ws", i), w, vecs[i].exp_ws);
      chk($sformatf("vec%0d_lat", i), lat, 3);
    end

    // Reset during BUSY drops an uncommitted store
    sel = 0;
    start_req(16'h0020, 16'h5555, 2'b11, ok);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", vl2, 0);
    chk("midrst_req_ready", rr2, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", vl2, 0);
    end
    chk("post_rst_req_ready", rr2, 1);
    do_req(16'h0020, 16'h0000, 2'b00, 0, rd, e, w, lat, ok);
    if (ok) chk("midrst_mem_kept", rd, 16'h0001);

    // Response held under back-pressure for 5 cycles
    do_req(16'h0010, 16'h0000, 2'b00, 5, rd, e, w, lat, ok);
    if (ok) chk("hold_load_rdata", rd, 16'hAA34);

    // Randomized ops on a pre-initialised region
    for (int i = 16'h40; i < 16'h80; i += 2) begin
      wd = 16'($urandom);
      model_op(16'(i), wd, 2'b11, er, ee, ew);
      do_req(16'(i), wd, 2'b11, 0, rd, e, w, lat, ok);
    end
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = 16'(DEPTH + $urandom_range(0, 600));
      else                            a = 16'(16'h40 + $urandom_range(0, 63));
      wd = 16'($urandom);
      wr = 2'($urandom_range(0, 3));
      model_op(a, wd, wr, er, ee, ew);
      do_req(a, wd, wr, 0, rd, e, w, lat, ok);
      if (!ok) continue;
      chk($sformatf("rand%0d_a%0h_wr%0d", n, a, wr), {rd, e, w}, {er, ee, ew});
    end

    // LATENCY=0 instance: 2 stores, 3 loads, 1 error
    sel = 1;
    vecs.delete();
    vecs.push_back('{1, 16'h0030, 16'h1111, 2'b11, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{1, 16'h0032, 16'h2233, 2'b11, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{1, 16'h0030, 16'h0000, 2'b00, 16'h1111, 1'b0, 1'b0});
    vecs.push_back('{1, 16'h0032, 16'h0000, 2'b00, 16'h2233, 1'b0, 1'b0});
    vecs.push_back('{1, 16'h0030, 16'h0000, 2'b00, 16'h1111, 1'b0, 1'b0});
    vecs.push_back('{1, 16'h0031, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0});
    foreach (vecs[i]) begin
      do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wr, 0, rd, e, w, lat, ok);
      if (!ok) continue;
      chk($sformatf("l0_vec%0d_resp", i), {rd, e, w},
          {vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_ws});
      chk($sformatf("l0_vec%0d_lat", i), lat, 1);
    end
`ifdef DMEM_PERF_CNT_EN
    chk("perf_rd_cnt", prd0, 3);
    chk("perf_wr_cnt", pwr0, 2);
    chk("perf_err_cnt", per0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
